// File: rtl/regfile_pkg.sv
// Shared state encoding and default parameter values for the multiport register file.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 18;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_BYPASS   = 1;
  localparam int DEF_ZERO_REG = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address select, write-first forwarding, hard-zero entry 0.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  input  logic              wr_commit_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0] sel_data;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Only committed writes are forwarded; entry 0 override comes last so it wins.
  always_comb begin
    sel_data = mem_i[rd_addr_i];
    if (BYPASS != 0 && wr_commit_i && (wr_addr_i == rd_addr_i)) begin
      sel_data = wr_data_i;
    end
    if (ZERO_REG != 0 && (rd_addr_i == '0)) begin
      sel_data = '0;
    end
  end

  always_comb begin
    rd_fire    = active_i && rd_en_i;
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? sel_data : rd_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/multiport_regfile.sv
// Register file with one write port, NUM_RD registered read ports and a
// sequential clear engine that zeroes one entry per cycle after reset or clr_req.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_commit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    wr_commit = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      ST_CLEAR: begin
        // The clear engine owns the write port; clr_req here does not restart it.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        wr_drop_d = wr_en;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        wr_commit = wr_en && !clr_req;
        wr_drop_d = wr_en && clr_req;
        mem_we    = wr_commit && !(ZERO_REG != 0 && (wr_addr == '0));
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // NOTE: the storage array carries no reset; the CLEAR sequence is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ready   = (state_q == ST_READY);
  assign wr_drop = wr_drop_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .clk        (clk),
      .rst        (rst),
      .active_i   (ready),
      .rd_en_i    (rd_en[p]),
      .rd_addr_i  (rd_addr[p*ADDR_W +: ADDR_W]),
      .mem_i      (mem_q),
      .wr_commit_i(wr_commit),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_data_o  (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid_o (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench: three configurations (bypass, read-old, zero-reg) share one
// randomized/directed stimulus stream and are checked against an array model.
module tb_multiport_regfile;

  localparam int NI = 3;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [17:0] wr_data;
  logic        clr_req;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;

  logic [35:0] rd_data_w  [NI];
  logic [1:0]  rd_valid_w [NI];
  logic        ready_w    [NI];
  logic        wr_drop_w  [NI];

  multiport_regfile #(.DATA_W(18), .ADDR_W(4), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)) dut_byp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[0]),
    .rd_valid(rd_valid_w[0]), .ready(ready_w[0]), .wr_drop(wr_drop_w[0]));

  multiport_regfile #(.DATA_W(18), .ADDR_W(4), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) dut_old (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[1]),
    .rd_valid(rd_valid_w[1]), .ready(ready_w[1]), .wr_drop(wr_drop_w[1]));

  multiport_regfile #(.DATA_W(18), .ADDR_W(4), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_zr (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[2]),
    .rd_valid(rd_valid_w[2]), .ready(ready_w[2]), .wr_drop(wr_drop_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        drop;
    logic [1:0]  valid;
    logic [35:0] held;
  } rec_t;

  rec_t        cyc_q [NI][$];
  logic [17:0] dat_q [NI*2][$];

  logic [17:0] m_mem  [NI][16];
  logic [17:0] m_held [NI][2];
  int          m_left [NI];

  int n_checks = 0;
  int n_errors = 0;

  function automatic bit cfg_bypass(int i);
    return i != 1;
  endfunction

  function automatic bit cfg_zero(int i);
    return i == 2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a clear simply zeroes the whole array and blocks the file
  // for 16 cycles; reads and writes are only honoured while no clear is pending.
  task automatic model_step();
    rec_t        r;
    logic        wcommit;
    logic [3:0]  a;
    logic [17:0] d;
    for (int i = 0; i < NI; i++) begin
      r.drop  = 1'b0;
      r.valid = 2'b00;
      if (rst) begin
        for (int k = 0; k < 16; k++) m_mem[i][k] = '0;
        m_left[i]    = 16;
        m_held[i][0] = '0;
        m_held[i][1] = '0;
      end else if (m_left[i] > 0) begin
        r.drop = wr_en;
        m_left[i]--;
      end else begin
        wcommit = wr_en && !clr_req;
        r.drop  = wr_en && clr_req;
        for (int p = 0; p < 2; p++) begin
          if (rd_en[p]) begin
            a = rd_addr[p*4 +: 4];
            if (cfg_zero(i) && a == 4'd0) d = '0;
            else if (cfg_bypass(i) && wcommit && wr_addr == a) d = wr_data;
            else d = m_mem[i][a];
            r.valid[p]   = 1'b1;
            m_held[i][p] = d;
            dat_q[i*2+p].push_back(d);
          end
        end
        if (wcommit && !(cfg_zero(i) && wr_addr == 4'd0)) m_mem[i][wr_addr] = wr_data;
        if (clr_req) begin
          for (int k = 0; k < 16; k++) m_mem[i][k] = '0;
          m_left[i] = 16;
        end
      end
      r.ready = (m_left[i] == 0);
      r.held  = {m_held[i][1], m_held[i][0]};
      cyc_q[i].push_back(r);
    end
  endtask

  // Monitor: runs on the falling edge, independent of the stimulus process.
  initial begin
    rec_t        r;
    logic [17:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (cyc_q[i].size() > 0) begin
          r = cyc_q[i].pop_front();
          check($sformatf("ready[%0d]", i), 64'(ready_w[i]), 64'(r.ready));
          check($sformatf("wr_drop[%0d]", i), 64'(wr_drop_w[i]), 64'(r.drop));
          check($sformatf("rd_valid[%0d]", i), 64'(rd_valid_w[i]), 64'(r.valid));
          for (int p = 0; p < 2; p++) begin
            if (rd_valid_w[i][p] === 1'b1) begin
              if (dat_q[i*2+p].size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_data[%0d][%0d]: got unexpected valid, expected none at %0t",
                         i, p, $time);
              end else begin
                e = dat_q[i*2+p].pop_front();
                check($sformatf("rd_data[%0d][%0d]", i, p), 64'(rd_data_w[i][p*18 +: 18]), 64'(e));
              end
            end else begin
              check($sformatf("rd_hold[%0d][%0d]", i, p), 64'(rd_data_w[i][p*18 +: 18]),
                    64'(r.held[p*18 +: 18]));
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    clr_req = 1'b0;
    rd_en   = 2'b00;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [17:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic set_rd(input int p, input logic [3:0] a);
    rd_en[p]         = 1'b1;
    rd_addr[p*4 +: 4] = a;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) m_left[i] = 16;
    rst     = 1'b1;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    idle();
    tick();
    rst = 1'b0;

    // Post-reset clear: writes are dropped, reads ignored, clr_req has no effect.
    for (int c = 0; c < 16; c++) begin
      idle();
      if (c == 3) set_wr(4'd2, 18'h15555);
      if (c == 5) set_rd(0, 4'd2);
      if (c == 9) clr_req = 1'b1;
      tick();
    end
    idle();
    for (int a = 0; a < 16; a += 2) begin
      idle();
      set_rd(0, 4'(a));
      set_rd(1, 4'(a + 1));
      tick();
    end

    // Write then read back one cycle later.
    idle(); set_wr(4'd5, 18'h3ABCD); tick();
    idle(); set_rd(0, 4'd5); tick();
    idle(); tick();

    // Same-cycle write and read on both ports.
    idle(); set_wr(4'd7, 18'h00011); tick();
    idle(); set_wr(4'd7, 18'h2FFFF); set_rd(0, 4'd7); set_rd(1, 4'd7); tick();
    idle(); set_rd(1, 4'd7); tick();

    // Entry 0 write, then same-cycle write/read of entry 0, then plain read.
    idle(); set_wr(4'd0, 18'h12345); tick();
    idle(); set_rd(0, 4'd0); set_rd(1, 4'd0); tick();
    idle(); set_wr(4'd0, 18'h00ABC); set_rd(0, 4'd0); tick();
    idle(); set_rd(1, 4'd0); tick();

    // Clear with a coincident write: dropped, not forwarded, entry reads zero afterwards.
    idle(); set_wr(4'd3, 18'h0F0F0); tick();
    idle(); set_wr(4'd3, 18'h3FFFF); clr_req = 1'b1; set_rd(0, 4'd3); tick();
    for (int c = 0; c < 16; c++) begin
      idle();
      tick();
    end
    idle(); set_rd(0, 4'd3); set_rd(1, 4'd5); tick();

    // Reset in the middle of a clear restarts the whole sequence.
    idle(); clr_req = 1'b1; tick();
    idle();
    for (int c = 0; c < 8; c++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int c = 0; c < 17; c++) tick();

    // Randomized traffic with occasional clears and resets.
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 249) == 0);
      wr_en   = 1'($urandom);
      wr_addr = 4'($urandom);
      wr_data = 18'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
      rd_en   = 2'($urandom);
      rd_addr = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[7:4] = wr_addr;
      if ($urandom_range(0, 5) == 0) rd_addr[3:0] = rd_addr[7:4];
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();
    @(negedge clk);
    #1;
    for (int q = 0; q < NI*2; q++) begin
      check($sformatf("drain_rd[%0d]", q), 64'(dat_q[q].size()), 64'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
